conv_layer_sequencer: RTL and testbench

Parametrised multi-layer top-level controller for the convolution/max-pool datapath. It sequences up to NUM_LAYERS layers. Each layer runs one kernel convolution per channel, then an optional max-pool. Start and done handshakes go to the conv and pool engines, and a watchdog catches a hung engine. It sits between the system-level ready/done interface and the conv and max-pool engines.

---
 rtl/conv_layer_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// Top-level sequencer for the conv/max-pool datapath: walks layers and
// channels, launches the conv and pool engines, and guards each engine wait
// with a watchdog. Outputs are decoded from the state register only.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   S_IDLE       | waiting for ready; datapath held in clear
//   S_CLEAR      | one-cycle datapath clear, layer/channel counters zeroed
//   S_CONV_START | one-cycle conv launch for the current channel
//   S_CONV_WAIT  | waiting for conv_done, watchdog running
//   S_POOL_START | one-cycle max-pool launch for the current layer
//   S_POOL_WAIT  | waiting for max_pool_done, watchdog running
//   S_LAYER_END  | one-cycle layer_done pulse, pick next layer or finish
//   S_DONE       | one-cycle done pulse, back to idle
//   S_ERROR      | engine hung; hold datapath in clear until abort
module conv_layer_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int MAX_CH     = 8,
  parameter int CH_W       = $clog2(MAX_CH + 1),
  parameter int LAYER_W    = $clog2(NUM_LAYERS + 1),
  parameter int TIMEOUT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready,
  input  logic [LAYER_W-1:0]    cfg_layers,
  input  logic [CH_W-1:0]       num_ch,
  input  logic [NUM_LAYERS-1:0] pool_en,
  input  logic                  conv_done,
  input  logic                  max_pool_done,
  input  logic                  abort,
  output logic                  busy,
  output logic                  dp_rst,
  output logic                  cin,
  output logic                  in_sel,
  output logic                  out_sel,
  output logic                  conv_start,
  output logic                  pool_start,
  output logic [LAYER_W-1:0]    layer_idx,
  output logic [CH_W-1:0]       ch_idx,
  output logic                  layer_done,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_CONV_START,
    S_CONV_WAIT,
    S_POOL_START,
    S_POOL_WAIT,
    S_LAYER_END,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [LAYER_W-1:0] LAYER_CAP = LAYER_W'(NUM_LAYERS);
  localparam logic [CH_W-1:0]    CH_CAP    = CH_W'(MAX_CH);
  // Down-counter load: terminal count (zero) is hit on the
  // (2**TIMEOUT_W-1)-th wait cycle, which is where the hang is declared.
  localparam logic [TIMEOUT_W-1:0] WD_LOAD = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t                  state_q, state_d;
  logic [LAYER_W-1:0]      layer_q, layer_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [LAYER_W-1:0]      cfg_layers_q, cfg_layers_d;
  logic [CH_W-1:0]         num_ch_q, num_ch_d;
  logic [NUM_LAYERS-1:0]   pool_en_q, pool_en_d;
  logic [TIMEOUT_W-1:0]    wd_q, wd_d;
  logic                    error_q, error_d;
  logic [LAYER_W-1:0]      layers_fix;
  logic [CH_W-1:0]         ch_fix;
  logic                    last_ch;
  logic                    last_layer;
  logic                    pool_here;
  logic                    wd_tc;

  assign layer_idx  = layer_q;
  assign ch_idx     = ch_q;
  assign error      = error_q;
  assign last_ch    = !(ch_q < (num_ch_q - CH_W'(1)));
  assign last_layer = (layer_q == (cfg_layers_q - LAYER_W'(1)));
  assign pool_here  = |(pool_en_q & (NUM_LAYERS'(1) << layer_q));
  assign wd_tc      = (wd_q == '0);

  // Zero/over-range fixup of the run configuration before it is latched.
  always_comb begin
    layers_fix = cfg_layers;
    if (cfg_layers == '0)            layers_fix = LAYER_W'(1);
    else if (cfg_layers > LAYER_CAP) layers_fix = LAYER_CAP;
    ch_fix = num_ch;
    if (num_ch == '0)                ch_fix = CH_W'(1);
    else if (num_ch > CH_CAP)        ch_fix = CH_CAP;
  end

  // State, counters, latched config and sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      layer_q      <= '0;
      ch_q         <= '0;
      wd_q         <= '0;
      error_q      <= 1'b0;
      cfg_layers_q <= LAYER_W'(1);
      num_ch_q     <= CH_W'(1);
      pool_en_q    <= '0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      ch_q         <= ch_d;
      wd_q         <= wd_d;
      error_q      <= error_d;
      cfg_layers_q <= cfg_layers_d;
      num_ch_q     <= num_ch_d;
      pool_en_q    <= pool_en_d;
    end
  end

  // Next-state, counter updates and per-state output decode.
  always_comb begin
    state_d      = state_q;
    layer_d      = layer_q;
    ch_d         = ch_q;
    wd_d         = wd_q;
    error_d      = error_q;
    cfg_layers_d = cfg_layers_q;
    num_ch_d     = num_ch_q;
    pool_en_d    = pool_en_q;
    busy         = 1'b0;
    dp_rst       = 1'b0;
    cin          = 1'b0;
    in_sel       = 1'b0;
    out_sel      = 1'b0;
    conv_start   = 1'b0;
    pool_start   = 1'b0;
    layer_done   = 1'b0;
    done         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        dp_rst = 1'b1;
        if (ready && !abort) begin
          cfg_layers_d = layers_fix;
          num_ch_d     = ch_fix;
          pool_en_d    = pool_en;
          error_d      = 1'b0;
          state_d      = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy    = 1'b1;
        dp_rst  = 1'b1;
        layer_d = '0;
        ch_d    = '0;
        state_d = abort ? S_IDLE : S_CONV_START;
      end
      S_CONV_START: begin
        busy       = 1'b1;
        cin        = 1'b1;
        conv_start = 1'b1;
        wd_d       = WD_LOAD;
        state_d    = abort ? S_IDLE : S_CONV_WAIT;
      end
      S_CONV_WAIT: begin
        busy = 1'b1;
        cin  = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (conv_done) begin
          if (!last_ch) begin
            ch_d    = ch_q + CH_W'(1);
            state_d = S_CONV_START;
          end else begin
            ch_d    = '0;
            state_d = pool_here ? S_POOL_START : S_LAYER_END;
          end
        end else if (wd_tc) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q - TIMEOUT_W'(1);
        end
      end
      S_POOL_START: begin
        busy       = 1'b1;
        cin        = 1'b1;
        in_sel     = 1'b1;
        out_sel    = 1'b1;
        pool_start = 1'b1;
        wd_d       = WD_LOAD;
        state_d    = abort ? S_IDLE : S_POOL_WAIT;
      end
      S_POOL_WAIT: begin
        busy    = 1'b1;
        cin     = 1'b1;
        in_sel  = 1'b1;
        out_sel = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (max_pool_done) begin
          state_d = S_LAYER_END;
        end else if (wd_tc) begin
          error_d = 1'b1;
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q - TIMEOUT_W'(1);
        end
      end
      S_LAYER_END: begin
        busy       = 1'b1;
        layer_done = 1'b1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (last_layer) begin
          state_d = S_DONE;
        end else begin
          layer_d = layer_q + LAYER_W'(1);
          state_d = S_CONV_START;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        busy   = 1'b1;
        dp_rst = 1'b1;
        if (abort) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer (TIMEOUT_W reduced to 4).
module tb_conv_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [2:0] cfg_layers;
  logic [3:0] num_ch;
  logic [3:0] pool_en;
  logic       conv_done;
  logic       max_pool_done;
  logic       abort;
  logic       busy, dp_rst, cin, in_sel, out_sel, conv_start, pool_start;
  logic [2:0] layer_idx;
  logic [3:0] ch_idx;
  logic       layer_done, done, error;

  conv_layer_sequencer #(
    .NUM_LAYERS(4),
    .MAX_CH(8),
    .TIMEOUT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ready(ready),
    .cfg_layers(cfg_layers),
    .num_ch(num_ch),
    .pool_en(pool_en),
    .conv_done(conv_done),
    .max_pool_done(max_pool_done),
    .abort(abort),
    .busy(busy),
    .dp_rst(dp_rst),
    .cin(cin),
    .in_sel(in_sel),
    .out_sel(out_sel),
    .conv_start(conv_start),
    .pool_start(pool_start),
    .layer_idx(layer_idx),
    .ch_idx(ch_idx),
    .layer_done(layer_done),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse/activity counters observed on the falling edge.
  int n_cs = 0, n_ps = 0, n_ld = 0, n_dn = 0, n_insel = 0, n_seldiff = 0;
  int ps_layer = -1;
  int cs_ch[$];
  int cs_layer[$];

  always @(negedge clk) begin
    if (conv_start === 1'b1) begin
      n_cs++;
      cs_ch.push_back(int'(ch_idx));
      cs_layer.push_back(int'(layer_idx));
    end
    if (pool_start === 1'b1) begin
      n_ps++;
      ps_layer = int'(layer_idx);
    end
    if (layer_done === 1'b1) n_ld++;
    if (done === 1'b1) n_dn++;
    if (in_sel === 1'b1) n_insel++;
    if (in_sel !== out_sel) n_seldiff++;
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout: observed no finish, required finish");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Accept a run, check CLEAR, scramble config, stop on the first conv_start cycle.
  task automatic start_run(input logic [2:0] l, input logic [3:0] c, input logic [3:0] p,
                           input string tag);
    cfg_layers = l;
    num_ch     = c;
    pool_en    = p;
    ready      = 1'b1;
    @(negedge clk);
    ready      = 1'b0;
    cfg_layers = 3'd7;
    num_ch     = 4'd15;
    pool_en    = 4'hF;
    check({tag, "_clear_busy"}, busy, 1);
    check({tag, "_clear_dp_rst"}, dp_rst, 1);
    check({tag, "_clear_error"}, error, 0);
    @(negedge clk);
    check({tag, "_first_conv_start"}, conv_start, 1);
  endtask

  // Engines answer 5 cycles after each launch; returns on the done cycle.
  task automatic run_auto(input string tag, input int budget);
    int cc;
    int pc;
    bit got;
    cc  = 0;
    pc  = 0;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      conv_done     = 1'b0;
      max_pool_done = 1'b0;
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (cc > 0) begin
          cc--;
          if (cc == 0) conv_done = 1'b1;
        end
        if (pc > 0) begin
          pc--;
          if (pc == 0) max_pool_done = 1'b1;
        end
        if (conv_start === 1'b1) cc = 5;
        if (pool_start === 1'b1) pc = 5;
        @(negedge clk);
      end
    end
    conv_done     = 1'b0;
    max_pool_done = 1'b0;
    check({tag, "_reached_done"}, got, 1);
  endtask

  int b_cs, b_ps, b_ld, b_dn, b_in, bq;

  task automatic snap();
    b_cs = n_cs; b_ps = n_ps; b_ld = n_ld; b_dn = n_dn; b_in = n_insel; bq = cs_ch.size();
  endtask

  initial begin
    rst = 1'b0; ready = 1'b0; cfg_layers = '0; num_ch = '0; pool_en = '0;
    conv_done = 1'b0; max_pool_done = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_dp_rst", dp_rst, 1);
    check("rst_layer_idx", layer_idx, 0);
    check("rst_ch_idx", ch_idx, 0);
    check("rst_error", error, 0);
    check("rst_done", done, 0);
    check("rst_cin", cin, 0);
    check("rst_conv_start", conv_start, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Basic run: 2 layers x 3 channels, pool after layer 0.
    snap();
    start_run(3'd2, 4'd3, 4'b0001, "basic");
    run_auto("basic", 200);
    @(negedge clk); #1;
    check("basic_idle_busy", busy, 0);
    check("basic_idle_dp_rst", dp_rst, 1);
    check("basic_conv_starts", n_cs - b_cs, 6);
    check("basic_pool_starts", n_ps - b_ps, 1);
    check("basic_pool_layer", ps_layer, 0);
    check("basic_layer_dones", n_ld - b_ld, 2);
    check("basic_dones", n_dn - b_dn, 1);
    check("basic_insel_cycles", n_insel - b_in, 6);
    check("basic_final_layer_idx", layer_idx, 1);
    check("basic_final_ch_idx", ch_idx, 0);
    check("basic_log_size", cs_ch.size() - bq, 6);
    for (int k = 0; k < 6 && (bq + k) < cs_ch.size(); k++) begin
      check($sformatf("basic_ch_seq%0d", k), cs_ch[bq + k], k % 3);
      check($sformatf("basic_layer_seq%0d", k), cs_layer[bq + k], k / 3);
    end

    // cfg_layers=0, num_ch=0 behave as 1.
    snap();
    start_run(3'd0, 4'd0, 4'b0000, "zero");
    run_auto("zero", 100);
    @(negedge clk); #1;
    check("zero_conv_starts", n_cs - b_cs, 1);
    check("zero_pool_starts", n_ps - b_ps, 0);
    check("zero_layer_dones", n_ld - b_ld, 1);
    check("zero_dones", n_dn - b_dn, 1);

    // num_ch=15 clamps to 8.
    snap();
    start_run(3'd1, 4'd15, 4'b0000, "clamp_ch");
    run_auto("clamp_ch", 200);
    @(negedge clk); #1;
    check("clamp_ch_conv_starts", n_cs - b_cs, 8);
    check("clamp_ch_last_ch", cs_ch[$], 7);
    check("clamp_ch_layer_dones", n_ld - b_ld, 1);

    // cfg_layers=7 clamps to 4.
    snap();
    start_run(3'd7, 4'd1, 4'b0000, "clamp_l");
    run_auto("clamp_l", 200);
    @(negedge clk); #1;
    check("clamp_l_conv_starts", n_cs - b_cs, 4);
    check("clamp_l_layer_dones", n_ld - b_ld, 4);
    check("clamp_l_dones", n_dn - b_dn, 1);
    check("clamp_l_final_layer", layer_idx, 3);

    // Reset during CONV_WAIT of layer 1.
    snap();
    start_run(3'd2, 4'd1, 4'b0000, "rstmid");
    @(negedge clk);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    check("rstmid_layer_done", layer_done, 1);
    @(negedge clk);
    check("rstmid_conv_start_l1", conv_start, 1);
    check("rstmid_layer_idx_l1", layer_idx, 1);
    @(negedge clk);
    check("rstmid_in_wait", cin, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rstmid_busy", busy, 0);
    check("rstmid_dp_rst", dp_rst, 1);
    check("rstmid_layer_idx", layer_idx, 0);
    check("rstmid_done", done, 0);
    @(negedge clk); #1;
    check("rstmid_no_done", n_dn - b_dn, 0);
    check("rstmid_still_idle", busy, 0);

    // Watchdog: conv engine never answers.
    start_run(3'd1, 4'd1, 4'b0000, "wd");
    repeat (15) @(negedge clk);
    check("wd_no_error_at_14", error, 0);
    check("wd_still_wait", cin, 1);
    @(negedge clk);
    check("wd_error_at_15", error, 1);
    check("wd_error_busy", busy, 1);
    check("wd_error_dp_rst", dp_rst, 1);
    check("wd_error_cin", cin, 0);
    repeat (3) @(negedge clk);
    check("wd_error_hold", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("wd_abort_idle", busy, 0);
    check("wd_error_sticky", error, 1);
    @(negedge clk);
    check("wd_error_sticky_idle", error, 1);
    start_run(3'd1, 4'd1, 4'b0000, "wd_restart");
    run_auto("wd_restart", 100);
    @(negedge clk); #1;

    // conv_done on the terminal watchdog cycle wins.
    start_run(3'd1, 4'd1, 4'b0000, "wd_edge");
    repeat (15) @(negedge clk);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    check("wd_edge_no_error", error, 0);
    check("wd_edge_layer_done", layer_done, 1);
    @(negedge clk);
    check("wd_edge_done", done, 1);
    @(negedge clk); #1;

    // Abort together with last-channel conv_done.
    snap();
    start_run(3'd1, 4'd1, 4'b0001, "abort");
    @(negedge clk);
    conv_done = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    abort     = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_dp_rst", dp_rst, 1);
    check("abort_no_pool_start", pool_start, 0);
    @(negedge clk); #1;
    check("abort_pool_cnt", n_ps - b_ps, 0);
    check("abort_layer_done_cnt", n_ld - b_ld, 0);
    check("abort_done_cnt", n_dn - b_dn, 0);

    // Spurious pool done in CONV_WAIT, simultaneous dones in POOL_WAIT.
    snap();
    start_run(3'd1, 4'd1, 4'b0001, "spur");
    @(negedge clk);
    max_pool_done = 1'b1;
    @(negedge clk);
    max_pool_done = 1'b0;
    check("spur_conv_wait_cin", cin, 1);
    check("spur_conv_wait_in_sel", in_sel, 0);
    check("spur_no_pool_start", pool_start, 0);
    check("spur_no_layer_done", layer_done, 0);
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    check("spur_pool_start", pool_start, 1);
    check("spur_pool_in_sel", in_sel, 1);
    check("spur_pool_out_sel", out_sel, 1);
    @(negedge clk);
    conv_done     = 1'b1;
    max_pool_done = 1'b1;
    @(negedge clk);
    conv_done     = 1'b0;
    max_pool_done = 1'b0;
    check("spur_layer_end", layer_done, 1);
    @(negedge clk);
    check("spur_done", done, 1);
    check("spur_single_layer_done", layer_done, 0);
    @(negedge clk); #1;
    check("spur_idle", busy, 0);
    check("spur_layer_done_cnt", n_ld - b_ld, 1);
    check("spur_conv_start_cnt", n_cs - b_cs, 1);
    check("sel_paths_agree", n_seldiff, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
